// File: rtl/ws_array_sequencer_if.sv
// ----------------------------------------------------------------------------
// ws_array_sequencer_if
// Bundles the job handshake and the memory/array control signals of the
// weight-stationary array sequencer.
//   master : job requester / observer (drives start, skip_weights, num_vecs)
//   slave  : the sequencer itself (drives status, memory reads, array gating)
// Signals:
//   start, skip_weights, num_vecs  job request, sampled together on accept
//   busy, done                     job status
//   w_rd_en, w_addr, load_row      weight memory read and per-row weight load
//   x_rd_en, x_addr, row_en        input memory read and left-edge skew gating
//   out_valid                      per-column bottom-row psum valid flags
// ----------------------------------------------------------------------------
interface ws_array_sequencer_if #(
  parameter int N  = 4,
  parameter int CW = 8,
  parameter int AW = 2
);
  logic          start;
  logic          skip_weights;
  logic [CW-1:0] num_vecs;
  logic          busy;
  logic          done;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [N-1:0]  load_row;
  logic          x_rd_en;
  logic [CW-1:0] x_addr;
  logic [N-1:0]  row_en;
  logic [N-1:0]  out_valid;

  modport master (
    output start, skip_weights, num_vecs,
    input  busy, done, w_rd_en, w_addr, load_row,
    input  x_rd_en, x_addr, row_en, out_valid
  );

  modport slave (
    input  start, skip_weights, num_vecs,
    output busy, done, w_rd_en, w_addr, load_row,
    output x_rd_en, x_addr, row_en, out_valid
  );
endinterface

// File: rtl/ws_array_sequencer.sv
// ----------------------------------------------------------------------------
// ws_array_sequencer
// Job controller for an N x N weight-stationary systolic array. An accepted
// start runs LOAD (one weight row per cycle, optional), STREAM (K input
// vectors, one per cycle) and DRAIN (array empties), then a one-cycle FIN
// that pulses done.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    ws_array_sequencer_if.slave (job handshake, memory reads,
//          per-row weight load, left-edge skew gating, column valid flags)
// All outputs are registered.
// ----------------------------------------------------------------------------
module ws_array_sequencer #(
  parameter int N  = 4,
  parameter int CW = 8,
  parameter int AW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  ws_array_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, FIN} state_t;

  // DRAIN spans 2N cycles: N for the last vector to cross the skew, N more
  // for its psum to fall through the rows and reach the last column.
  localparam int DW = (N > 1) ? $clog2(2 * N) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 1);
  localparam logic [AW-1:0] LAST_ROW   = AW'(N - 1);

  state_t        state;
  logic [CW-1:0] k_lat;       // K latched at accept
  logic [DW-1:0] drain_cnt;

  logic          busy_q;
  logic          done_q;
  logic          w_rd_en_q;
  logic [AW-1:0] w_addr_q;
  logic [N-1:0]  load_row_q;
  logic          x_rd_en_q;
  logic [CW-1:0] x_addr_q;
  logic [N-1:0]  row_en_q;
  logic [N-1:0]  out_valid_q;

  // Control FSM with registered outputs: every output value is decided on the
  // edge that enters the cycle in which it is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state is updated with <= so every branch reads pre-edge values;
      // blocking assignments here would let one decision see another's result.
      state     <= IDLE;
      k_lat     <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_rd_en_q <= 1'b0;
      w_addr_q  <= '0;
      x_rd_en_q <= 1'b0;
      x_addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            k_lat  <= bus.num_vecs;
            busy_q <= 1'b1;
            if (!bus.skip_weights) begin
              state     <= LOAD;
              w_rd_en_q <= 1'b1;
              w_addr_q  <= '0;
            end else if (bus.num_vecs == '0) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state     <= STREAM;
              x_rd_en_q <= 1'b1;
              x_addr_q  <= '0;
            end
          end
        end

        LOAD: begin
          if (w_addr_q == LAST_ROW) begin
            w_rd_en_q <= 1'b0;
            if (k_lat == '0) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state     <= STREAM;
              x_rd_en_q <= 1'b1;
              x_addr_q  <= '0;
            end
          end else begin
            w_addr_q <= w_addr_q + AW'(1);
          end
        end

        STREAM: begin
          // k_lat >= 1 here, so k_lat-1 is the index of the last vector.
          if (x_addr_q == k_lat - CW'(1)) begin
            state     <= DRAIN;
            x_rd_en_q <= 1'b0;
            drain_cnt <= '0;
          end else begin
            x_addr_q <= x_addr_q + CW'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= FIN;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        FIN: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Weight rows land one cycle after their read (memory latency), so
  // load_row is the one-hot of the previous cycle's read address.
  // row_en shifts the read-enable history down the rows (diagonal skew);
  // out_valid continues that history across the columns after the last row.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_row_q  <= '0;
      row_en_q    <= '0;
      out_valid_q <= '0;
    end else begin
      load_row_q  <= w_rd_en_q ? (N'(1) << w_addr_q) : '0;
      row_en_q    <= N'({row_en_q, x_rd_en_q});
      out_valid_q <= N'({out_valid_q, row_en_q[N-1]});
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.w_rd_en   = w_rd_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.load_row  = load_row_q;
  assign bus.x_rd_en   = x_rd_en_q;
  assign bus.x_addr    = x_addr_q;
  assign bus.row_en    = row_en_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/ws_array_sequencer.md
Name: ws_array_sequencer

Overview:
Controller for an N×N weight-stationary systolic array built from the team's weight-stationary PEs. On a start pulse it does three things in order. First, it optionally loads one weight row per cycle from weight memory. Second, it streams K input vectors from input memory with per-row diagonal skew enables. Third, it drains the array, flagging when each bottom-row column psum is valid. It sits between the array and its weight/input SRAMs and drives every PE's load_weight and the array-edge input gating.

Parameters:
N, 4, array dimension (rows = columns = N)
CW, 8, width of vector count and input address
AW, 2, weight row address width (= clog2(N), min 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a job; accepted only in IDLE
skip_weights  in  1  sampled with accepted start; 1 = reuse loaded weights, skip LOAD
num_vecs  in  CW  K = number of input vectors, sampled with accepted start
busy  out  1  high from the cycle after accepted start through the done cycle inclusive
done  out  1  one-cycle pulse at job completion
w_rd_en  out  1  weight memory read enable
w_addr  out  AW  weight row being read
load_row  out  N  one-hot; bit r drives load_weight of every PE in array row r
x_rd_en  out  1  input memory read enable
x_addr  out  CW  input vector index being read
row_en  out  N  bit r: row r left-edge input is live (external mux forces 0 when low)
out_valid  out  N  bit c: bottom-row psum_out of column c holds a valid result this cycle

Behaviour:
- Reset (synchronous, any state including mid-job): state=IDLE; all outputs 0; counters and skew/valid shift registers cleared. Any job in progress is abandoned; no done pulse.
- Memories have fixed 1-cycle read latency. The PE has 1-cycle latency per hop for both input and psum.
- States: IDLE, LOAD, STREAM, DRAIN, FIN.
- Let S be the cycle in which start=1 is sampled in IDLE.
- IDLE -> LOAD at S+1 when skip_weights=0. IDLE -> STREAM at S+1 when skip_weights=1.
- LOAD: lasts N cycles, S+1..S+N.
  - w_rd_en=1 and w_addr=r at cycle S+1+r.
  - load_row[r]=1 at cycle S+2+r, exactly one bit high at a time.
  - The final load_row[N-1] pulse at S+N+1 overlaps the first STREAM cycle. This is legal because the weight is captured before any row N-1 input arrives.
- STREAM: starts at T0 (S+N+1 after LOAD, S+1 when skipping).
  - x_rd_en=1 with x_addr=k at cycle T0+k, for k=0..K-1.
  - row_en[r]=1 during cycles T0+1+r .. T0+K+r. This is the diagonal skew.
  - After K issue cycles, go to DRAIN.
- K=0: no x_rd_en, row_en or out_valid. Go directly to FIN (done at T0).
- DRAIN: no new reads; skew and valid pipelines keep shifting.
  - out_valid[c]=1 during cycles T0+N+1+c .. T0+N+K+c.
  - Implement both row_en and out_valid as shift registers of the x_rd_en history, not as per-cycle counters.
- FIN: a single cycle at T0+2N+K (K>0). done=1, busy=1, then IDLE next cycle.
- start while busy: ignored, with no queuing. start in the FIN cycle: ignored.
- num_vecs and skip_weights are latched at accept; later changes have no effect.
- x_addr wraps modulo 2^CW, so K up to 2^CW-1 is supported.
- Outputs are registered. When inactive, w_addr and x_addr hold their last value and carry no meaning while their enable is low.

Test Plan:
- Load + stream: N=4, K=3, start at cycle 0, skip_weights=0 -> w_addr 0..3 at cycles 1..4; load_row 0001,0010,0100,1000 at 2..5; x_rd_en 5..7; row_en[0] 6..8; row_en[3] 9..11; out_valid[0] 10..12; out_valid[3] 13..15; done at 16; busy 1..16.
- Skip weights: N=4, K=2, skip_weights=1, start at 0 -> no w_rd_en or load_row; x_rd_en 1..2; out_valid[0] 6..7; out_valid[3] 9..10; done at 11.
- Numerical end-to-end with 4×4 PE array: W = identity, inputs x0=[1,2,3,4], x1=[5,6,7,8] -> column c outputs x0[c] then x1[c] on its out_valid cycles.
- K=0 with skip_weights=1, start at 0 -> done at 1; no x_rd_en, row_en or out_valid ever high.
- Start during busy at cycle 8 of the first scenario -> ignored; timing identical; single done at 16.
- Reset asserted at cycle 9 of the first scenario -> from cycle 10 all outputs 0, state IDLE, no done pulse. A new start at cycle 12 then reproduces the first-scenario timing offset by 12.
